// File: rtl/baudgen_nco_pkg.sv
// Shared constants for the NCO baud generator: rate-select encodings and
// the elaboration-time increment calculation.
package baudgen_nco_pkg;

    typedef logic [1:0] rate_sel_t;

    localparam rate_sel_t RATE_115200 = 2'd0;
    localparam rate_sel_t RATE_9600   = 2'd1;
    localparam rate_sel_t RATE_57600  = 2'd2;
    localparam rate_sel_t RATE_230400 = 2'd3;

    // round(baud * oversample * 2^acc_w / clk_freq) in 64-bit arithmetic
    function automatic longint unsigned calc_inc(
        input longint unsigned baud,
        input longint unsigned oversample,
        input longint unsigned acc_w,
        input longint unsigned clk_freq
    );
        longint unsigned num;
        num = (baud * oversample) << acc_w;
        return (num + (clk_freq >> 1)) / clk_freq;
    endfunction

    function automatic bit inc_in_range(
        input longint unsigned inc,
        input longint unsigned acc_w
    );
        return (inc != 64'd0) && (inc < (64'd1 << acc_w));
    endfunction

endpackage

// File: rtl/baud_nco.sv
// Phase accumulator: adds inc each edge; carry reports the wrap of this edge's add.
module baud_nco #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [ACC_W-1:0] inc,
    output logic             carry
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W:0]   sum;

    // clr wins over the adder, so a wrap on a clearing edge is discarded
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, inc};
        acc_d = clr ? '0 : sum[ACC_W-1:0];
        carry = sum[ACC_W] & ~clr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/baudgen_nco.sv
// Four-rate NCO baud generator producing oversample, mid-bit and bit-end ticks,
// with bit-boundary rate switching and a resync input for start-bit alignment.
module baudgen_nco
    import baudgen_nco_pkg::*;
#(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD0      = 115200,
    parameter int BAUD1      = 9600,
    parameter int BAUD2      = 57600,
    parameter int BAUD3      = 230400,
    parameter int OVERSAMPLE = 16,
    parameter int ACC_W      = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] sel,
    input  logic       resync,
    output logic       os_tick,
    output logic       mid_tick,
    output logic       baud_tick
);

    localparam int OS_W = $clog2(OVERSAMPLE);

    localparam longint unsigned INC0_L = calc_inc(BAUD0, OVERSAMPLE, ACC_W, CLK_FREQ);
    localparam longint unsigned INC1_L = calc_inc(BAUD1, OVERSAMPLE, ACC_W, CLK_FREQ);
    localparam longint unsigned INC2_L = calc_inc(BAUD2, OVERSAMPLE, ACC_W, CLK_FREQ);
    localparam longint unsigned INC3_L = calc_inc(BAUD3, OVERSAMPLE, ACC_W, CLK_FREQ);

    localparam logic [ACC_W-1:0] INC0 = ACC_W'(INC0_L);
    localparam logic [ACC_W-1:0] INC1 = ACC_W'(INC1_L);
    localparam logic [ACC_W-1:0] INC2 = ACC_W'(INC2_L);
    localparam logic [ACC_W-1:0] INC3 = ACC_W'(INC3_L);

    localparam logic [OS_W-1:0] MID_CNT  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] LAST_CNT = OS_W'(OVERSAMPLE - 1);

    localparam bit INC_OK = inc_in_range(INC0_L, ACC_W) && inc_in_range(INC1_L, ACC_W) &&
                            inc_in_range(INC2_L, ACC_W) && inc_in_range(INC3_L, ACC_W);
    localparam bit GEOM_OK = (OVERSAMPLE >= 4) && (OVERSAMPLE <= 64) &&
                             ((OVERSAMPLE & (OVERSAMPLE - 1)) == 0) &&
                             (ACC_W >= 16) && (ACC_W <= 31);

    if (!INC_OK) begin : g_bad_inc
        $error("baudgen_nco: a rate increment is zero or does not fit in ACC_W bits");
    end
    if (!GEOM_OK) begin : g_bad_geom
        $error("baudgen_nco: OVERSAMPLE or ACC_W outside the supported range");
    end

    rate_sel_t        sel_q;
    rate_sel_t        sel_d;
    logic [OS_W-1:0]  os_cnt_q;
    logic [OS_W-1:0]  os_cnt_d;
    logic             os_tick_q;
    logic             os_tick_d;
    logic             mid_tick_q;
    logic             mid_tick_d;
    logic             baud_tick_q;
    logic             baud_tick_d;
    logic [ACC_W-1:0] inc_sel;
    logic             clr;
    logic             carry;

    baud_nco #(
        .ACC_W(ACC_W)
    ) u_nco (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (inc_sel),
        .carry(carry)
    );

    // Rate only switches while idle or on the bit-end edge, so a bit never mixes rates
    always_comb begin
        clr = !en || resync;

        case (sel_q)
            RATE_115200: inc_sel = INC0;
            RATE_9600:   inc_sel = INC1;
            RATE_57600:  inc_sel = INC2;
            default:     inc_sel = INC3;
        endcase

        os_tick_d   = carry;
        mid_tick_d  = carry && (os_cnt_q == MID_CNT);
        baud_tick_d = carry && (os_cnt_q == LAST_CNT);

        os_cnt_d = os_cnt_q;
        if (clr) begin
            os_cnt_d = '0;
        end else if (carry) begin
            os_cnt_d = os_cnt_q + OS_W'(1);
        end

        sel_d = sel_q;
        if (!en || baud_tick_d) begin
            sel_d = sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q       <= RATE_115200;
            os_cnt_q    <= '0;
            os_tick_q   <= 1'b0;
            mid_tick_q  <= 1'b0;
            baud_tick_q <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            os_cnt_q    <= os_cnt_d;
            os_tick_q   <= os_tick_d;
            mid_tick_q  <= mid_tick_d;
            baud_tick_q <= baud_tick_d;
        end
    end

    assign os_tick   = os_tick_q;
    assign mid_tick  = mid_tick_q;
    assign baud_tick = baud_tick_q;

endmodule

// File: tb/tb_baudgen_nco.sv
// Directed bench for baudgen_nco at the default 12 MHz / x16 configuration;
// tick edge numbers are counted from the first enabled edge of each scenario.
module tb_baudgen_nco;
    import baudgen_nco_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] sel;
    logic       resync;
    logic       os_tick;
    logic       mid_tick;
    logic       baud_tick;

    always #5 clk = ~clk;

    baudgen_nco dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sel      (sel),
        .resync   (resync),
        .os_tick  (os_tick),
        .mid_tick (mid_tick),
        .baud_tick(baud_tick)
    );

    typedef struct {
        string name;
        int    kind;
        int    idx;
        int    exp_edge;
    } vec_t;

    int n_compared   = 0;
    int n_mismatched = 0;
    int edge_n       = 0;
    int bad_coincide = 0;
    int os_at_last_baud = 0;
    int os_q[$];
    int mid_q[$];
    int baud_q[$];
    vec_t vecs[10];

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input longint actual, input longint lo, input longint hi);
        n_compared++;
        if (actual < lo || actual > hi) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [1:0] s, input logic r);
        en     = e;
        sel    = s;
        resync = r;
    endtask

    task automatic clear_log();
        edge_n = 0;
        os_at_last_baud = 0;
        os_q.delete();
        mid_q.delete();
        baud_q.delete();
    endtask

    // Advance n rising edges, sampling 1 time unit after each and logging tick edges
    task automatic step_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            edge_n++;
            if (os_tick) os_q.push_back(edge_n);
            if (mid_tick) mid_q.push_back(edge_n);
            if (baud_tick) begin
                baud_q.push_back(edge_n);
                os_at_last_baud = os_q.size();
            end
            if (mid_tick && baud_tick) bad_coincide++;
            if ((mid_tick || baud_tick) && !os_tick) bad_coincide++;
        end
    endtask

    function automatic int get_edge(input int kind, input int idx);
        case (kind)
            0:       return (idx < os_q.size())   ? os_q[idx]   : -1;
            1:       return (idx < mid_q.size())  ? mid_q[idx]  : -1;
            default: return (idx < baud_q.size()) ? baud_q[idx] : -1;
        endcase
    endfunction

    initial begin
        int min_gap;
        int max_gap;

        // kind: 0 = os_tick, 1 = mid_tick, 2 = baud_tick
        vecs[0] = '{"s1_os0",    0, 0,   7};
        vecs[1] = '{"s1_os1",    0, 1,  14};
        vecs[2] = '{"s1_os2",    0, 2,  20};
        vecs[3] = '{"s1_os15",   0, 15, 105};
        vecs[4] = '{"s1_mid0",   1, 0,  53};
        vecs[5] = '{"s1_baud0",  2, 0, 105};
        vecs[6] = '{"s1_mid1",   1, 1, 157};
        vecs[7] = '{"s1_baud1",  2, 1, 209};
        vecs[8] = '{"s1_os16",   0, 16, 111};
        vecs[9] = '{"s1_os31",   0, 31, 209};

        rst = 1'b1;
        applyStimulus(1'b0, RATE_115200, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reset_os", os_tick, 0);
        checkOutput("reset_mid", mid_tick, 0);
        checkOutput("reset_baud", baud_tick, 0);
        @(negedge clk);
        rst = 1'b0;
        step_edges(2);
        checkOutput("idle_os", os_tick, 0);

        // Scenario 1: default rate from a clean start
        applyStimulus(1'b1, RATE_115200, 1'b0);
        clear_log();
        step_edges(220);
        for (int i = 0; i < 10; i++) begin
            checkOutput(vecs[i].name, get_edge(vecs[i].kind, vecs[i].idx), vecs[i].exp_edge);
        end
        checkOutput("s1_mid_count", mid_q.size(), 2);
        checkOutput("s1_baud_count", baud_q.size(), 2);

        // en low for one edge clears, restart repeats the first-tick latency
        applyStimulus(1'b0, RATE_115200, 1'b0);
        step_edges(1);
        checkOutput("en_clear_os", os_tick, 0);
        applyStimulus(1'b1, RATE_115200, 1'b0);
        clear_log();
        step_edges(10);
        checkOutput("en_restart_os0", get_edge(0, 0), 7);

        // Resync on edge 40 of a bit, where the sixth carry would land
        applyStimulus(1'b0, RATE_115200, 1'b0);
        step_edges(1);
        applyStimulus(1'b1, RATE_115200, 1'b0);
        clear_log();
        step_edges(39);
        checkOutput("rs_pre_os_count", os_q.size(), 5);
        applyStimulus(1'b1, RATE_115200, 1'b1);
        step_edges(1);
        checkOutput("rs_dropped_tick", os_tick, 0);
        applyStimulus(1'b1, RATE_115200, 1'b0);
        clear_log();
        step_edges(110);
        checkOutput("rs_os0", get_edge(0, 0), 7);
        checkOutput("rs_mid0", get_edge(1, 0), 53);
        checkOutput("rs_baud0", get_edge(2, 0), 105);

        // sel 0 -> 3 on edge 60: bit ends at 105, next bit at 230400 (residual phase 2147444)
        applyStimulus(1'b0, RATE_115200, 1'b0);
        step_edges(1);
        applyStimulus(1'b1, RATE_115200, 1'b0);
        clear_log();
        step_edges(60);
        applyStimulus(1'b1, RATE_230400, 1'b0);
        step_edges(120);
        checkOutput("sel_mid0", get_edge(1, 0), 53);
        checkOutput("sel_baud0", get_edge(2, 0), 105);
        checkOutput("sel_mid1", get_edge(1, 1), 131);
        checkOutput("sel_baud1", get_edge(2, 1), 157);
        checkOutput("sel_baud_count", baud_q.size(), 2);

        // 9600 baud: INC1 = 214748, one bit is 1250.002 edges
        applyStimulus(1'b0, RATE_9600, 1'b0);
        step_edges(1);
        applyStimulus(1'b1, RATE_9600, 1'b0);
        clear_log();
        step_edges(15001);
        checkOutput("b9600_mid0", get_edge(1, 0), 626);
        checkOutput("b9600_baud0", get_edge(2, 0), 1251);
        checkOutput("b9600_baud_count", baud_q.size(), 12);
        min_gap = 1 << 30;
        max_gap = 0;
        for (int i = 1; i < baud_q.size(); i++) begin
            if (baud_q[i] - baud_q[i-1] < min_gap) min_gap = baud_q[i] - baud_q[i-1];
            if (baud_q[i] - baud_q[i-1] > max_gap) max_gap = baud_q[i] - baud_q[i-1];
        end
        check_range("b9600_min_gap", min_gap, 1250, 1251);
        check_range("b9600_max_gap", max_gap, 1250, 1251);

        // Long run at 115200: 40000 edges hold 384 bits / 6144 oversample ticks nominally
        applyStimulus(1'b0, RATE_115200, 1'b0);
        step_edges(1);
        applyStimulus(1'b1, RATE_115200, 1'b0);
        clear_log();
        step_edges(40000);
        check_range("lr_baud_count", baud_q.size(), 383, 385);
        check_range("lr_os_count", os_q.size(), 6143, 6145);
        checkOutput("lr_os_per_baud", os_at_last_baud, 16 * baud_q.size());

        // Async reset mid-bit, taken just after the edge-33 os_tick
        applyStimulus(1'b0, RATE_115200, 1'b0);
        step_edges(1);
        applyStimulus(1'b1, RATE_115200, 1'b0);
        clear_log();
        step_edges(33);
        checkOutput("pre_rst_os", os_tick, 1);
        rst = 1'b1;
        #1;
        checkOutput("rst_async_os", os_tick, 0);
        for (int i = 0; i < 3; i++) begin
            step_edges(1);
            checkOutput("rst_hold_os", os_tick, 0);
            checkOutput("rst_hold_baud", baud_tick, 0);
        end
        rst = 1'b0;
        clear_log();
        step_edges(1);
        checkOutput("post_rst_first_os", os_tick, 0);
        checkOutput("post_rst_first_mid", mid_tick, 0);
        step_edges(109);
        checkOutput("post_rst_os0", get_edge(0, 0), 7);
        checkOutput("post_rst_mid0", get_edge(1, 0), 53);
        checkOutput("post_rst_baud0", get_edge(2, 0), 105);

        checkOutput("tick_coincidence", bad_coincide, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
